// File: rtl/svpwm_pkg.sv
// Shared types, constants and selector tables for the space-vector PWM block.
package svpwm_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_XYZ  = 3'd1,
        S_SECT = 3'd2,
        S_SUM  = 3'd3,
        S_DIV  = 3'd4,
        S_CMP  = 3'd5,
        S_OUT  = 3'd6
    } state_t;

    localparam logic signed [31:0] SQRT3_2_Q15 = 32'sd28378;

    localparam int unsigned XYZ_W   = 17;
    localparam int unsigned T_W     = 17;
    localparam int unsigned CMP_W   = 16;
    localparam int unsigned DIV_N_W = 32;
    localparam int unsigned DIV_D_W = 18;
    localparam int unsigned DIV_Q_W = 16;

    typedef enum logic [2:0] {
        OP_ZERO = 3'd0,
        OP_X    = 3'd1,
        OP_NX   = 3'd2,
        OP_Y    = 3'd3,
        OP_NY   = 3'd4,
        OP_Z    = 3'd5,
        OP_NZ   = 3'd6
    } op_sel_t;

    typedef enum logic [1:0] {
        T_A = 2'd0,
        T_B = 2'd1,
        T_C = 2'd2
    } t_sel_t;

    typedef struct packed {
        op_sel_t t1;
        op_sel_t t2;
    } t12_sel_t;

    typedef struct packed {
        t_sel_t a;
        t_sel_t b;
        t_sel_t c;
    } cmp_map_t;

    function automatic logic [2:0] sector_of(input logic [2:0] n);
        case (n)
            3'd1:    sector_of = 3'd2;
            3'd2:    sector_of = 3'd6;
            3'd3:    sector_of = 3'd1;
            3'd4:    sector_of = 3'd4;
            3'd5:    sector_of = 3'd3;
            3'd6:    sector_of = 3'd5;
            default: sector_of = 3'd1;
        endcase
    endfunction

    function automatic t12_sel_t t12_of(input logic [2:0] n);
        case (n)
            3'd1:    t12_of = '{t1: OP_Z,  t2: OP_Y};
            3'd2:    t12_of = '{t1: OP_Y,  t2: OP_NX};
            3'd3:    t12_of = '{t1: OP_NZ, t2: OP_X};
            3'd4:    t12_of = '{t1: OP_NX, t2: OP_Z};
            3'd5:    t12_of = '{t1: OP_X,  t2: OP_NY};
            3'd6:    t12_of = '{t1: OP_NY, t2: OP_NZ};
            default: t12_of = '{t1: OP_ZERO, t2: OP_ZERO};
        endcase
    endfunction

    function automatic cmp_map_t cmp_map_of(input logic [2:0] n);
        case (n)
            3'd1:    cmp_map_of = '{a: T_B, b: T_A, c: T_C};
            3'd2:    cmp_map_of = '{a: T_A, b: T_C, c: T_B};
            3'd4:    cmp_map_of = '{a: T_C, b: T_B, c: T_A};
            3'd5:    cmp_map_of = '{a: T_C, b: T_A, c: T_B};
            3'd6:    cmp_map_of = '{a: T_B, b: T_C, c: T_A};
            default: cmp_map_of = '{a: T_A, b: T_B, c: T_C};
        endcase
    endfunction

    function automatic logic signed [XYZ_W:0] pick_op(
        input op_sel_t                   s,
        input logic signed [XYZ_W-1:0]   x,
        input logic signed [XYZ_W-1:0]   y,
        input logic signed [XYZ_W-1:0]   z
    );
        case (s)
            OP_X:    pick_op =  (XYZ_W+1)'(x);
            OP_NX:   pick_op = -(XYZ_W+1)'(x);
            OP_Y:    pick_op =  (XYZ_W+1)'(y);
            OP_NY:   pick_op = -(XYZ_W+1)'(y);
            OP_Z:    pick_op =  (XYZ_W+1)'(z);
            OP_NZ:   pick_op = -(XYZ_W+1)'(z);
            default: pick_op = '0;
        endcase
    endfunction

    // Negative dwell times are not realisable; floor them at zero.
    function automatic logic [T_W-1:0] clamp0(input logic signed [XYZ_W:0] v);
        clamp0 = v[XYZ_W] ? '0 : v[T_W-1:0];
    endfunction

    function automatic logic [CMP_W-1:0] pick_t(
        input t_sel_t           s,
        input logic [CMP_W-1:0] ta,
        input logic [CMP_W-1:0] tb,
        input logic [CMP_W-1:0] tc
    );
        case (s)
            T_B:     pick_t = tb;
            T_C:     pick_t = tc;
            default: pick_t = ta;
        endcase
    endfunction

endpackage

// File: rtl/svpwm_div.sv
// Fixed-latency restoring divider: 16-bit quotient, one bit per cycle, MSB first.
module svpwm_div
    import svpwm_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [DIV_N_W-1:0] i_dividend,
    input  logic [DIV_D_W-1:0] i_divisor,
    output logic [DIV_Q_W-1:0] o_quot,
    output logic               o_done_c
);

    localparam int unsigned DEN_W = DIV_D_W + DIV_Q_W - 1;
    localparam int unsigned CNT_W = $clog2(DIV_Q_W + 1);

    logic [DIV_N_W-1:0] r_rem;
    logic [DEN_W-1:0]   r_den;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_ge;

    // Caller guarantees quotient < 2^16, so the first trial starts at divisor << 15.
    assign w_ge     = (DEN_W'(r_rem) >= r_den);
    assign o_done_c = (r_cnt == CNT_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            o_quot <= '0;
        end else if (i_start) begin
            r_rem  <= i_dividend;
            r_den  <= DEN_W'(i_divisor) << (DIV_Q_W - 1);
            r_cnt  <= CNT_W'(DIV_Q_W);
            o_quot <= '0;
        end else if (r_cnt != '0) begin
            if (w_ge) begin
                r_rem <= r_rem - DIV_N_W'(r_den);
            end
            o_quot <= {o_quot[DIV_Q_W-2:0], w_ge};
            r_den  <= r_den >> 1;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/svpwm.sv
// Space-vector PWM: alpha/beta voltage -> sector and centre-aligned compare values.
module svpwm
    import svpwm_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 2500
)(
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iSvpwm_en,
    input  logic [15:0] iValpha,
    input  logic [15:0] iVbeta,
    output logic        oSvpwm_done,
    output logic [2:0]  oSector,
    output logic [15:0] oCmpA,
    output logic [15:0] oCmpB,
    output logic [15:0] oCmpC
);

    localparam logic signed [31:0] HP_S  = 32'(HALF_PERIOD);
    localparam logic [DIV_D_W-1:0] HP_18 = DIV_D_W'(HALF_PERIOD);
    localparam logic [CMP_W-1:0]   HP_16 = CMP_W'(HALF_PERIOD);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_en_d;
    logic signed [15:0]        r_va;
    logic signed [15:0]        r_vb;
    logic signed [XYZ_W-1:0]   r_x;
    logic signed [XYZ_W-1:0]   r_y;
    logic signed [XYZ_W-1:0]   r_z;
    logic [2:0]                r_n;
    logic [T_W-1:0]            r_t1;
    logic [T_W-1:0]            r_t2;
    logic                      r_ovm;
    logic [CMP_W-1:0]          r_ta;
    logic [CMP_W-1:0]          r_tb;
    logic [CMP_W-1:0]          r_tc;

    logic                      w_start;
    logic signed [31:0]        w_va32;
    logic signed [31:0]        w_vb32;
    logic signed [31:0]        w_vbh;
    logic signed [31:0]        w_prod_kva;
    logic signed [31:0]        w_kva;
    logic signed [31:0]        w_nkva;
    logic signed [31:0]        w_u2;
    logic signed [31:0]        w_u3;
    logic [2:0]                w_n;
    t12_sel_t                  w_t12;
    logic [DIV_D_W-1:0]        w_sum;
    logic                      w_ovm;
    logic                      w_div_start;
    logic                      w_div_done_c;
    logic [DIV_Q_W-1:0]        w_div_q;
    logic [DIV_N_W-1:0]        w_dividend;
    logic [CMP_W-1:0]          w_t1_eff;
    logic [CMP_W-1:0]          w_t2_eff;
    logic [DIV_D_W-1:0]        w_rest;
    logic [CMP_W-1:0]          w_ta;
    logic [CMP_W-1:0]          w_tb;
    logic [CMP_W-1:0]          w_tc;
    cmp_map_t                  w_map;

    assign w_start = (r_state == S_IDLE) && iSvpwm_en && !r_en_d;

    // Q15 projections shared by the X/Y/Z and sector stages.
    assign w_va32     = 32'(r_va);
    assign w_vb32     = 32'(r_vb);
    assign w_vbh      = w_vb32 >>> 1;
    assign w_prod_kva = SQRT3_2_Q15 * w_va32;
    assign w_kva      = w_prod_kva >>> 15;
    assign w_nkva     = (-w_prod_kva) >>> 15;
    assign w_u2       = w_kva - w_vbh;
    assign w_u3       = -w_kva - w_vbh;
    assign w_n        = {w_u3 > 32'sd0, w_u2 > 32'sd0, r_vb > 16'sd0};
    assign w_t12      = t12_of(w_n);

    assign w_sum      = DIV_D_W'(r_t1) + DIV_D_W'(r_t2);
    assign w_ovm      = (w_sum > HP_18);
    assign w_dividend = DIV_N_W'(r_t1) * DIV_N_W'(HALF_PERIOD);

    // Overmodulated dwell times are rescaled so T1'+T2' fills the half period.
    assign w_t1_eff = r_ovm ? w_div_q : CMP_W'(r_t1);
    assign w_t2_eff = r_ovm ? (HP_16 - w_div_q) : CMP_W'(r_t2);
    assign w_rest   = HP_18 - DIV_D_W'(w_t1_eff) - DIV_D_W'(w_t2_eff);
    assign w_ta     = CMP_W'(w_rest >> 1);
    assign w_tb     = w_ta + w_t1_eff;
    assign w_tc     = w_tb + w_t2_eff;
    assign w_map    = cmp_map_of(r_n);

    svpwm_div u_div (
        .i_clk      (iClk),
        .i_rst_n    (iRst_n),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_sum),
        .o_quot     (w_div_q),
        .o_done_c   (w_div_done_c)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_start = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_XYZ;
            S_XYZ:  w_state_nxt = S_SECT;
            S_SECT: w_state_nxt = S_SUM;
            S_SUM: begin
                if (w_ovm) begin
                    w_state_nxt = S_DIV;
                    w_div_start = 1'b1;
                end else begin
                    w_state_nxt = S_CMP;
                end
            end
            S_DIV:  if (w_div_done_c) w_state_nxt = S_CMP;
            S_CMP:  w_state_nxt = S_OUT;
            S_OUT:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers, each stage written only in its own state.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_en_d      <= 1'b0;
            r_va        <= '0;
            r_vb        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_n         <= '0;
            r_t1        <= '0;
            r_t2        <= '0;
            r_ovm       <= 1'b0;
            r_ta        <= '0;
            r_tb        <= '0;
            r_tc        <= '0;
            oSvpwm_done <= 1'b0;
            oSector     <= '0;
            oCmpA       <= '0;
            oCmpB       <= '0;
            oCmpC       <= '0;
        end else begin
            r_en_d      <= iSvpwm_en;
            oSvpwm_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_va <= $signed(iValpha);
                        r_vb <= $signed(iVbeta);
                    end
                end
                S_XYZ: begin
                    r_x <= XYZ_W'((HP_S * w_vb32) >>> 15);
                    r_y <= XYZ_W'((HP_S * (w_kva + w_vbh)) >>> 15);
                    r_z <= XYZ_W'((HP_S * (w_nkva + w_vbh)) >>> 15);
                end
                S_SECT: begin
                    r_n  <= w_n;
                    r_t1 <= clamp0(pick_op(w_t12.t1, r_x, r_y, r_z));
                    r_t2 <= clamp0(pick_op(w_t12.t2, r_x, r_y, r_z));
                end
                S_SUM: r_ovm <= w_ovm;
                S_CMP: begin
                    r_ta <= w_ta;
                    r_tb <= w_tb;
                    r_tc <= w_tc;
                end
                S_OUT: begin
                    oSector     <= sector_of(r_n);
                    oCmpA       <= pick_t(w_map.a, r_ta, r_tb, r_tc);
                    oCmpB       <= pick_t(w_map.b, r_ta, r_tb, r_tc);
                    oCmpC       <= pick_t(w_map.c, r_ta, r_tb, r_tc);
                    oSvpwm_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_svpwm.sv
// Directed self-checking bench for svpwm at HALF_PERIOD = 2500.
module tb_svpwm;

    logic        iClk      = 1'b0;
    logic        iRst_n    = 1'b0;
    logic        iSvpwm_en = 1'b0;
    logic [15:0] iValpha   = '0;
    logic [15:0] iVbeta    = '0;
    logic        oSvpwm_done;
    logic [2:0]  oSector;
    logic [15:0] oCmpA;
    logic [15:0] oCmpB;
    logic [15:0] oCmpC;

    int n_checks = 0;
    int n_errors = 0;

    svpwm #(.HALF_PERIOD(2500)) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iSvpwm_en   (iSvpwm_en),
        .iValpha     (iValpha),
        .iVbeta      (iVbeta),
        .oSvpwm_done (oSvpwm_done),
        .oSector     (oSector),
        .oCmpA       (oCmpA),
        .oCmpB       (oCmpB),
        .oCmpC       (oCmpC)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        int d;
        n_checks++;
        d = obs - exp;
        if (d < 0) d = -d;
        assert (d <= tol) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic chk_outs(input string tag, input int sec, input int a, input int b, input int c);
        chk({tag, ".sector"}, int'(oSector), sec, 0);
        chk({tag, ".cmpA"},   int'(oCmpA),   a,   1);
        chk({tag, ".cmpB"},   int'(oCmpB),   b,   1);
        chk({tag, ".cmpC"},   int'(oCmpC),   c,   1);
    endtask

    // One start edge at edge k, scrambled inputs afterwards, then latency and result checks.
    task automatic run_vec(input string tag, input int va, input int vb, input int lat_exp,
                           input int sec, input int a, input int b, input int c);
        int lat;
        @(negedge iClk);
        iValpha   = 16'(va);
        iVbeta    = 16'(vb);
        iSvpwm_en = 1'b1;
        @(posedge iClk);
        #1;
        iSvpwm_en = 1'b0;
        iValpha   = 16'($urandom);
        iVbeta    = 16'($urandom);
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge iClk);
            #1;
            if (oSvpwm_done) lat = i;
        end
        chk({tag, ".latency"}, lat, lat_exp, 0);
        chk_outs(tag, sec, a, b, c);
        @(posedge iClk);
        #1;
        chk({tag, ".done_width"}, int'(oSvpwm_done), 0, 0);
        chk({tag, ".hold_cmpB"}, int'(oCmpB), b, 1);
    endtask

    initial begin
        int pulses;

        // Reset state
        repeat (3) @(posedge iClk);
        #1;
        chk("reset.done", int'(oSvpwm_done), 0, 0);
        chk_outs("reset", 0, 0, 0, 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        repeat (2) @(posedge iClk);

        // Zero vector, nominal sector points, every sector, overmodulation
        run_vec("zero",   0,      0,      5,  1, 1250, 1250, 1250);
        run_vec("deg30",  14189,  8192,   5,  1, 625,  1250, 1875);
        run_vec("deg90",  0,      16384,  5,  2, 1250, 625,  1875);
        run_vec("deg150", -14189, 8192,   5,  3, 1875, 625,  1250);
        run_vec("deg210", -14189, -8192,  5,  4, 1875, 1250, 625);
        run_vec("deg270", 0,      -16384, 5,  5, 1250, 1875, 625);
        run_vec("deg330", 14189,  -8192,  5,  6, 625,  1875, 1250);
        run_vec("ovm",    32767,  18918,  21, 1, 0,    1250, 2500);

        // Busy: second edge at k+3 and enable held high for 30 cycles
        @(negedge iClk);
        iValpha   = 16'(14189);
        iVbeta    = 16'(8192);
        iSvpwm_en = 1'b1;
        @(posedge iClk);
        #1;
        iSvpwm_en = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge iClk);
            #1;
            if (oSvpwm_done) pulses++;
            if (i == 2)  iSvpwm_en = 1'b1;
            if (i == 32) iSvpwm_en = 1'b0;
        end
        chk("busy.pulses", pulses, 1, 0);
        chk_outs("busy", 1, 625, 1250, 1875);

        // Reset during the divide, then a clean restart
        @(negedge iClk);
        iValpha   = 16'(32767);
        iVbeta    = 16'(18918);
        iSvpwm_en = 1'b1;
        @(posedge iClk);
        #1;
        iSvpwm_en = 1'b0;
        repeat (10) @(posedge iClk);
        #1;
        iRst_n = 1'b0;
        #1;
        chk("midrst.done", int'(oSvpwm_done), 0, 0);
        chk_outs("midrst", 0, 0, 0, 0);
        @(negedge iClk);
        @(negedge iClk);
        iRst_n = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge iClk);
            #1;
            if (oSvpwm_done) pulses++;
        end
        chk("midrst.no_done", pulses, 0, 0);
        run_vec("restart", 14189, 8192, 5, 1, 625, 1250, 1875);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/svpwm.md
SVPWM -- requirements
Module: svpwm

Interface
REQ-001 The block SHALL have parameter HALF_PERIOD, default 2500, meaning the peak count of the centre-aligned (up/down) PWM carrier. Legal range is 2..32767.
REQ-002 The block SHALL have these ports:
- iClk  in  1  system clock.
- iRst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- iSvpwm_en  in  1  start request; rising edge only.
- iValpha  in  16  signed Q1.15 alpha voltage; 1.0 = Vdc/sqrt(3).
- iVbeta  in  16  signed Q1.15 beta voltage, same scale.
- oSvpwm_done  out  1  one-cycle result-valid pulse.
- oSector  out  3  sector 1..6.
- oCmpA, oCmpB, oCmpC  out  16 each  unsigned compare values, 0..HALF_PERIOD.

Function
REQ-003 The block SHALL start only on a rising edge of iSvpwm_en (high now, low on the previous clock) while in S_IDLE. It SHALL latch iValpha and iVbeta on that edge.
REQ-004 The FSM SHALL use states S_IDLE, S_XYZ, S_SECT, S_SUM, S_DIV, S_CMP, S_OUT.
- Transitions: IDLE->XYZ->SECT->SUM.
- SUM->CMP if T1+T2<=HALF_PERIOD, otherwise SUM->DIV.
- DIV runs 16 cycles, then ->CMP.
- CMP->OUT->IDLE.
REQ-005 S_XYZ SHALL compute X, Y, Z using K=28378 (sqrt3/2 in Q15), 32-bit signed products, and >>>15 with 17-bit signed results:
- X=(H*vb)>>>15
- Y=(H*(((K*va)>>>15)+(vb>>>1)))>>>15
- Z=(H*((-(K*va)>>>15)+(vb>>>1)))>>>15
REQ-006 S_SECT SHALL form N=(vb>0)+2*(U2>0)+4*(U3>0), where U2=((K*va)>>>15)-(vb>>>1) and U3=-((K*va)>>>15)-(vb>>>1).
REQ-007 The sector map SHALL be N: 3->1, 1->2, 5->3, 4->4, 6->5, 2->6. N=0 and N=7 SHALL map to sector 1.
REQ-008 The (T1,T2) selection by N SHALL be:
- 1: (Z,Y)
- 2: (Y,-X)
- 3: (-Z,X)
- 4: (-X,Z)
- 5: (X,-Y)
- 6: (-Y,-Z)
- 0/7: (0,0)
Negative results SHALL clamp to 0.
REQ-009 Overmodulation (S_DIV) SHALL use a 16-iteration restoring divider to compute T1'=(T1*HALF_PERIOD)/(T1+T2), truncated, and T2'=HALF_PERIOD-T1'.
REQ-010 S_CMP SHALL compute Ta=(HALF_PERIOD-T1-T2)>>1, Tb=Ta+T1, Tc=Tb+T2.
REQ-011 The output map (oCmpA,oCmpB,oCmpC) by N SHALL be:
- 1: (Tb,Ta,Tc)
- 2: (Ta,Tc,Tb)
- 3: (Ta,Tb,Tc)
- 4: (Tc,Tb,Ta)
- 5: (Tc,Ta,Tb)
- 6: (Tb,Tc,Ta)
- 0/7: as 3
REQ-012 S_OUT SHALL register oCmpA/B/C and oSector and pulse oSvpwm_done high for exactly one cycle. Outputs SHALL hold until the next S_OUT.
REQ-013 Latency SHALL be measured from the start edge k: oSvpwm_done is high after edge k+5 without overmodulation and after edge k+21 with it.
REQ-014 Rising edges of iSvpwm_en while the FSM is not in S_IDLE SHALL be ignored. iSvpwm_en held high SHALL produce one computation only.
REQ-015 Input changes after the latch edge SHALL NOT affect the running computation.

Reset
REQ-016 Asserting iRst_n low SHALL immediately do the following, including mid-computation or mid-division:
- state <= S_IDLE
- oSvpwm_done <= 0
- oSector <= 0
- oCmpA/B/C <= 0
- the enable-edge history register <= 0
- all intermediates <= 0
REQ-017 After reset release, the first rising edge of iSvpwm_en SHALL start a normal computation.

Structure
REQ-018 The shared package svpwm_pkg SHALL hold the state encoding, SQRT3_2_Q15=28378, and the N->sector and N->(T1,T2)/output-map selector constants.
REQ-019 The divider SHALL be a sub-module, svpwm_div, with start/done handshake and fixed 16-cycle latency. All other logic SHALL stay in svpwm.

Verification (HALF_PERIOD=2500; compare tolerance ±1 LSB)
REQ-020 Zero vector: va=0, vb=0, one en edge -> done at k+5, oSector=1, oCmpA=oCmpB=oCmpC=1250.
REQ-021 30 deg, magnitude 0.5: va=14189, vb=8192 -> oSector=1, T1=T2=625, oCmpA=625, oCmpB=1250, oCmpC=1875, latency 5.
REQ-022 90 deg: va=0, vb=16384 -> N=1, oSector=2, X=1250, T1=Z=625, T2=Y=625, oCmpA=1250, oCmpB=625, oCmpC=1875.
REQ-023 Overmodulation: va=32767, vb=18918 -> S_DIV entered, done at k+21, T1'=T2'=1250, oCmpA=0, oCmpB=1250, oCmpC=2500.
REQ-024 Busy handling: a second en edge at k+3, plus en held high for 30 cycles -> exactly one oSvpwm_done pulse.
REQ-025 Reset during S_DIV (k+10) -> all outputs 0 next cycle and no done pulse; a new en edge then reproduces the REQ-021 result.
